// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, ALU op codes, control-FSM state codes and control word
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    localparam logic [1:0] SRCB_B        = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } mc_state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       instr_retire;
        logic       halted;
    } mc_ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// rtl/mc_output_decode.sv - Moore decode of FSM state into the datapath control word
module mc_output_decode
    import mips_pkg::*;
(
    input  mc_state_t i_state,
    output mc_ctrl_t  o_ctrl
);

    // Unlisted fields stay 0; unused codes 13-15 fall through to all-zero.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALU_OP_ADD;
                o_ctrl.pc_src    = PC_SRC_ALU;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.pc_write  = 1'b1;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = SRCB_IMM_SHL2;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEMREAD: begin
                o_ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.mem_to_reg   = 1'b1;
                o_ctrl.reg_write    = 1'b1;
                o_ctrl.instr_retire = 1'b1;
            end
            S_MEMWRITE: begin
                o_ctrl.iord         = 1'b1;
                o_ctrl.mem_write    = 1'b1;
                o_ctrl.instr_retire = 1'b1;
            end
            S_EXECUTE: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_B;
                o_ctrl.alu_op    = ALU_OP_RTYPE;
            end
            S_ALUWB: begin
                o_ctrl.reg_dst      = 1'b1;
                o_ctrl.reg_write    = 1'b1;
                o_ctrl.instr_retire = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a    = 1'b1;
                o_ctrl.alu_src_b    = SRCB_B;
                o_ctrl.alu_op       = ALU_OP_SUB;
                o_ctrl.pc_src       = PC_SRC_ALUOUT;
                o_ctrl.branch       = 1'b1;
                o_ctrl.instr_retire = 1'b1;
            end
            S_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            S_ADDIWB: begin
                o_ctrl.reg_write    = 1'b1;
                o_ctrl.instr_retire = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_src       = PC_SRC_JUMP;
                o_ctrl.pc_write     = 1'b1;
                o_ctrl.instr_retire = 1'b1;
            end
            S_HALT: begin
                o_ctrl.halted = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the multicycle MIPS core
module multicycle_control
    import mips_pkg::*;
#(
    parameter bit TRAP_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       instr_retire,
    output logic       halted,
    output logic [3:0] state
);

    mc_state_t r_state;
    mc_state_t w_next_state;
    mc_ctrl_t  w_ctrl;
    logic      w_run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JUMP;
                    default:      w_next_state = TRAP_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR:   w_next_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_EXECUTE:  w_next_state = S_ALUWB;
            S_ADDIEX:   w_next_state = S_ADDIWB;
            S_HALT:     w_next_state = S_HALT;
            default:    w_next_state = S_FETCH;
        endcase
    end

    mc_output_decode u_decode (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    // The state register already reads FETCH during reset, so only enables need masking.
    assign w_run = ~reset;

    assign iord         = w_ctrl.iord;
    assign reg_dst      = w_ctrl.reg_dst;
    assign mem_to_reg   = w_ctrl.mem_to_reg;
    assign alu_src_a    = w_ctrl.alu_src_a;
    assign alu_src_b    = w_ctrl.alu_src_b;
    assign alu_op       = w_ctrl.alu_op;
    assign pc_src       = w_ctrl.pc_src;
    assign mem_write    = w_run & w_ctrl.mem_write;
    assign ir_write     = w_run & w_ctrl.ir_write;
    assign reg_write    = w_run & w_ctrl.reg_write;
    assign instr_retire = w_run & w_ctrl.instr_retire;
    assign halted       = w_run & w_ctrl.halted;
    assign pc_en        = w_run & (w_ctrl.pc_write | (w_ctrl.branch & zero));
    assign state        = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'b100011;
    logic       zero = 1'b0;
    wire  [15:0] o0, o1;
    wire  [3:0]  s0, s1;
    int n_assert = 0;
    int n_fail = 0;
    logic [5:0] ops [6];

    always #5 clk = ~clk;

    // o = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
    //      alu_src_b[1:0], alu_op[1:0], pc_src[1:0], pc_en, instr_retire, halted}
    multicycle_control #(.TRAP_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .iord(o0[15]), .mem_write(o0[14]), .ir_write(o0[13]), .reg_dst(o0[12]),
        .mem_to_reg(o0[11]), .reg_write(o0[10]), .alu_src_a(o0[9]), .alu_src_b(o0[8:7]),
        .alu_op(o0[6:5]), .pc_src(o0[4:3]), .pc_en(o0[2]), .instr_retire(o0[1]),
        .halted(o0[0]), .state(s0)
    );

    multicycle_control #(.TRAP_ILLEGAL(1'b1)) dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .iord(o1[15]), .mem_write(o1[14]), .ir_write(o1[13]), .reg_dst(o1[12]),
        .mem_to_reg(o1[11]), .reg_write(o1[10]), .alu_src_a(o1[9]), .alu_src_b(o1[8:7]),
        .alu_op(o1[6:5]), .pc_src(o1[4:3]), .pc_en(o1[2]), .instr_retire(o1[1]),
        .halted(o1[0]), .state(s1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outputs straight from the per-state output table.
    function automatic logic [15:0] exp_out(input int st, input logic z, input bit rst);
        logic iord_e, mw, irw, rd, m2r, rw, asa, pcw, br, ret, hlt;
        logic [1:0] asb, aop, psrc;
        {iord_e, mw, irw, rd, m2r, rw, asa, pcw, br, ret, hlt} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            0:  begin asb = 2'b01; irw = 1; pcw = 1; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  iord_e = 1;
            4:  begin m2r = 1; rw = 1; ret = 1; end
            5:  begin iord_e = 1; mw = 1; ret = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; ret = 1; end
            8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; br = 1; ret = 1; end
            9:  begin asa = 1; asb = 2'b10; end
            10: begin rw = 1; ret = 1; end
            11: begin psrc = 2'b10; pcw = 1; ret = 1; end
            12: hlt = 1;
            default: ;
        endcase
        if (rst) {mw, irw, rw, ret, hlt, pcw, br} = '0;
        return {iord_e, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, pcw | (br & z), ret, hlt};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // Called at #1 after a posedge with both DUTs in FETCH; returns likewise.
    task automatic run_instr(input logic [5:0] op, input int zsel);
        int path [5];
        int len;
        int retires = 0;
        case (op)
            6'b100011: begin len = 5; path = '{0, 1, 2, 3, 4};  end
            6'b101011: begin len = 4; path = '{0, 1, 2, 5, 0};  end
            6'b000000: begin len = 4; path = '{0, 1, 6, 7, 0};  end
            6'b000100: begin len = 3; path = '{0, 1, 8, 0, 0};  end
            6'b001000: begin len = 4; path = '{0, 1, 9, 10, 0}; end
            6'b000010: begin len = 3; path = '{0, 1, 11, 0, 0}; end
            default:   begin len = 2; path = '{0, 1, 0, 0, 0};  end
        endcase
        opcode = op;
        for (int i = 0; i < len; i++) begin
            zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : zsel[0];
            @(negedge clk);
            chk("state0", 32'(s0), 32'(path[i]));
            chk("ctrl0", 32'(o0), 32'(exp_out(path[i], zero, 1'b0)));
            chk("state1", 32'(s1), 32'(path[i]));
            chk("ctrl1", 32'(o1), 32'(exp_out(path[i], zero, 1'b0)));
            if (o0[1]) retires++;
            @(posedge clk);
            #1;
        end
        chk("retire_count", 32'(retires), is_legal(op) ? 32'd1 : 32'd0);
    endtask

    task automatic do_reset(input int ncyc);
        reset = 1'b1;
        #1;
        chk("rst_ctrl0", 32'(o0), 32'(exp_out(0, zero, 1'b1)));
        chk("rst_ctrl1", 32'(o1), 32'(exp_out(0, zero, 1'b1)));
        chk("rst_state1", 32'(s1), 32'd0);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            chk("rst_hold0", 32'(o0), 32'(exp_out(0, zero, 1'b1)));
            chk("rst_hold1", 32'(o1), 32'(exp_out(0, zero, 1'b1)));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op;
        ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};

        repeat (3) begin
            @(negedge clk);
            chk("reset_ctrl0", 32'(o0), 32'(exp_out(0, zero, 1'b1)));
            chk("reset_state0", 32'(s0), 32'd0);
            chk("reset_ctrl1", 32'(o1), 32'(exp_out(0, zero, 1'b1)));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(OP_LW, -1);
        run_instr(OP_RTYPE, -1);
        run_instr(OP_BEQ, 1);
        run_instr(OP_BEQ, 0);
        run_instr(OP_SW, -1);
        run_instr(OP_ADDI, -1);
        run_instr(OP_J, -1);

        run_instr(6'b111111, -1);
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            chk("halt_state1", 32'(s1), 32'd12);
            chk("halt_ctrl1", 32'(o1), 32'(exp_out(12, zero, 1'b0)));
            chk("nop_state0", 32'(s0), 32'(k % 2));
            @(posedge clk);
            #1;
        end
        do_reset(2);

        // Reset arriving mid-cycle in MEMWRITE must drop mem_write without a clock.
        opcode = OP_SW;
        repeat (3) @(posedge clk);
        #1;
        chk("memwrite_state0", 32'(s0), 32'd5);
        chk("memwrite_we0", 32'(o0[14]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_we0", 32'(o0[14]), 32'd0);
        chk("async_we1", 32'(o1[14]), 32'd0);
        chk("async_state0", 32'(s0), 32'd0);
        chk("async_state1", 32'(s1), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        repeat (150) begin
            int idx;
            idx = int'($urandom_range(0, 6));
            if (idx < 6) begin
                op = ops[idx];
            end else begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end
            run_instr(op, -1);
            if (!is_legal(op)) do_reset(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
